matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
Controller for the 3x3 MAC-array matrix multiplier (nine MAC units; unit ij gets row operand i and column operand j). It holds two 3x3 operand matrices A and B loaded over a simple write port. On a start pulse it clears the array, streams the three inner-product steps into it, and waits for the array to settle. It then captures the nine accumulator results and presents them on a valid/ready output. It sits between the host/register side and the MAC array, and owns the array's load and clear signals.

Parameters:
DW, 4, operand element width (matches MAC data inputs)
ACCW, 10, accumulator/result element width (matches MAC outputs)
MAC_LAT, 1, cycles from the last load cycle until the MAC outputs are stable; range 1..7

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  operand write strobe
wr_sel  in  1  0 = matrix A, 1 = matrix B
wr_addr  in  4  element index, row-major, 0..8 (addr = 3*row + col)
wr_data  in  DW  element value, unsigned
start  in  1  begin multiply; single-cycle request
busy  out  1  high from start acceptance until result handshake completes
data_w1, data_w2, data_w3  out  DW  to MAC row operands
data_x1, data_x2, data_x3  out  DW  to MAC column operands
load  out  1  to MAC array, accumulate enable
clear  out  1  to MAC array, accumulator clear
res_in  in  9*ACCW  packed MAC outputs; element (i,j), 0-based, at [(3*i+j)*ACCW +: ACCW]
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  9*ACCW  captured C = A x B, same packing as res_in

Behaviour:
- Reset (async): state = IDLE; busy, load, clear, res_valid = 0; all data_w*/data_x* = 0; res_data = 0; A and B storage = 0.
- All outputs are registered.
- Writes:
  - Accepted only when busy = 0 (IDLE state); wr_en in any other state is ignored.
  - wr_addr > 8 is ignored.
  - A write takes effect at the sampling edge, so a write and start in the same cycle uses the new value.
- States: IDLE -> CLR -> FEED (k = 0,1,2) -> DRAIN (MAC_LAT cycles) -> HOLD -> IDLE.
- IDLE: start = 1 moves to CLR and sets busy = 1 at that edge. start is ignored in all other states; no queuing.
- CLR: clear = 1 and load = 0 for exactly one cycle (cycle 1 after acceptance).
- FEED k (cycles 2, 3, 4):
  - load = 1, clear = 0.
  - data_w(i+1) = A[i][k] and data_x(j+1) = B[k][j] for i, j = 0..2.
  - Giving MAC ij the sum over k of A[i][k]*B[k][j].
- DRAIN: load = 0; data_w*/data_x* = 0. A counter runs MAC_LAT cycles. On the last DRAIN edge, res_in is captured into res_data and res_valid is set to 1.
- Latency: res_valid rises in cycle 5 + MAC_LAT after the start edge (cycle 6 at default).
- HOLD:
  - res_valid = 1 and res_data stay stable until res_valid & res_ready at a clock edge.
  - That edge clears res_valid and busy and returns to IDLE.
  - The earliest next start is the following cycle.
- Width: each element is at most 3*15*15 = 675, which is below 2^ACCW at the defaults. No saturation or overflow detection; res_data is the raw MAC value.
- Operand storage is not modified by a multiply, so a repeated start recomputes the same result.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values and storage cleared. The MAC array is re-cleared by the next CLR.
- clear and load are never high in the same cycle.

Test Plan:
- All A and B elements = 3, start, res_ready = 1 -> clear in cycle 1; load in cycles 2-4 with every data_w*/data_x* = 3; res_valid in cycle 6 with all nine elements = 27.
- A = identity, B = 1..9 row-major, start -> res_data equals B (element (i,j) = 3*i+j+1). Check data_w1 = 1,0,0 across FEED k = 0,1,2.
- All elements = 15 -> every element = 675. Also with MAC_LAT = 3: res_valid in cycle 8.
- Hold res_ready = 0 for 5 cycles after res_valid -> res_valid and res_data stable, busy = 1. start and wr_en pulses during busy/HOLD are ignored, so a re-read after completion shows unchanged storage and a single result.
- Write to wr_addr = 9 and 15 -> no storage change. Write plus start in the same IDLE cycle -> the new value is used.
- Assert rst during FEED k = 1 -> same-cycle load = 0, busy = 0, outputs zero. A full reload and start then gives the correct result with no residue from the aborted run.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Sequencer for a 3x3 MAC-array matrix multiplier: holds operands A and B,
// streams the three inner-product steps into the array and captures C = A x B.
module matmul_sequencer #(
    parameter int DW      = 4,
    parameter int ACCW    = 10,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              start,
    output logic              busy,
    output logic [DW-1:0]     data_w1,
    output logic [DW-1:0]     data_w2,
    output logic [DW-1:0]     data_w3,
    output logic [DW-1:0]     data_x1,
    output logic [DW-1:0]     data_x2,
    output logic [DW-1:0]     data_x3,
    output logic              load,
    output logic              clear,
    input  logic [9*ACCW-1:0] res_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [9*ACCW-1:0] res_data
);

    // state  | meaning
    // IDLE   | accepting operand writes, waiting for start
    // CLR    | clear pulse to the MAC array
    // FEED   | load step k (k_cnt = 0..2) into the array
    // DRAIN  | waiting MAC_LAT cycles for accumulators to settle
    // HOLD   | result presented, waiting for res_ready
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(MAC_LAT - 1);

    state_t            state, state_nxt;
    logic [1:0]        k_cnt, k_nxt;
    logic [2:0]        drain_cnt, drain_nxt;
    logic              busy_nxt, load_nxt, clear_nxt, res_valid_nxt;
    logic [9*ACCW-1:0] res_data_nxt;
    logic              feed_en;
    logic [1:0]        feed_k;
    logic [3:0]        b_row;
    logic [DW-1:0]     w_nxt [3];
    logic [DW-1:0]     x_nxt [3];
    logic [DW-1:0]     a_mem [9];
    logic [DW-1:0]     b_mem [9];

    always_comb begin
        state_nxt     = state;
        k_nxt         = k_cnt;
        drain_nxt     = drain_cnt;
        busy_nxt      = busy;
        clear_nxt     = 1'b0;
        res_valid_nxt = res_valid;
        res_data_nxt  = res_data;
        feed_en       = 1'b0;
        feed_k        = 2'd0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLR;
                    busy_nxt  = 1'b1;
                    clear_nxt = 1'b1;
                end
            end
            ST_CLR: begin
                state_nxt = ST_FEED;
                k_nxt     = 2'd0;
                feed_en   = 1'b1;
                feed_k    = 2'd0;
            end
            ST_FEED: begin
                if (k_cnt == 2'd2) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_INIT;
                end else begin
                    k_nxt   = k_cnt + 2'd1;
                    feed_en = 1'b1;
                    feed_k  = k_cnt + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 3'd0) begin
                    state_nxt     = ST_HOLD;
                    res_valid_nxt = 1'b1;
                    res_data_nxt  = res_in;
                end else begin
                    drain_nxt = drain_cnt - 3'd1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_nxt     = ST_IDLE;
                    res_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        load_nxt = feed_en;

        // Row operand i takes A[i][k]; column operand j takes B[k][j].
        b_row    = ({2'b00, feed_k} << 1) + {2'b00, feed_k};
        w_nxt[0] = feed_en ? a_mem[{2'b00, feed_k}]        : '0;
        w_nxt[1] = feed_en ? a_mem[4'd3 + {2'b00, feed_k}] : '0;
        w_nxt[2] = feed_en ? a_mem[4'd6 + {2'b00, feed_k}] : '0;
        x_nxt[0] = feed_en ? b_mem[b_row]                  : '0;
        x_nxt[1] = feed_en ? b_mem[b_row + 4'd1]           : '0;
        x_nxt[2] = feed_en ? b_mem[b_row + 4'd2]           : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_cnt     <= 2'd0;
            drain_cnt <= 3'd0;
            busy      <= 1'b0;
            load      <= 1'b0;
            clear     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            data_w1   <= '0;
            data_w2   <= '0;
            data_w3   <= '0;
            data_x1   <= '0;
            data_x2   <= '0;
            data_x3   <= '0;
        end else begin
            state     <= state_nxt;
            k_cnt     <= k_nxt;
            drain_cnt <= drain_nxt;
            busy      <= busy_nxt;
            load      <= load_nxt;
            clear     <= clear_nxt;
            res_valid <= res_valid_nxt;
            res_data  <= res_data_nxt;
            data_w1   <= w_nxt[0];
            data_w2   <= w_nxt[1];
            data_w3   <= w_nxt[2];
            data_x1   <= x_nxt[0];
            data_x2   <= x_nxt[1];
            data_x3   <= x_nxt[2];
        end
    end

    // Operand storage only changes while idle, so a running multiply sees a fixed A and B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (wr_en && (state == ST_IDLE) && (wr_addr <= 4'd8)) begin
            if (wr_sel) begin
                b_mem[wr_addr] <= wr_data;
            end else begin
                a_mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: two instances (MAC_LAT 1 and 3) share stimulus,
// each driving its own behavioural MAC array; results compared to a matrix-product model.
module tb_matmul_sequencer;

    localparam int DW   = 4;
    localparam int ACCW = 10;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic              wr_sel;
    logic [3:0]        wr_addr;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic              res_ready;
    logic [1:0]        busy, load, clear, res_valid;
    logic [DW-1:0]     wv [2][3];
    logic [DW-1:0]     xv [2][3];
    logic [9*ACCW-1:0] res_in [2];
    logic [9*ACCW-1:0] res_data [2];
    logic [ACCW-1:0]   acc [2][9];

    logic [DW-1:0]     ref_a [9];
    logic [DW-1:0]     ref_b [9];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(.DW(DW), .ACCW(ACCW), .MAC_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy[0]),
        .data_w1(wv[0][0]), .data_w2(wv[0][1]), .data_w3(wv[0][2]),
        .data_x1(xv[0][0]), .data_x2(xv[0][1]), .data_x3(xv[0][2]),
        .load(load[0]), .clear(clear[0]), .res_in(res_in[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready), .res_data(res_data[0])
    );

    matmul_sequencer #(.DW(DW), .ACCW(ACCW), .MAC_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy[1]),
        .data_w1(wv[1][0]), .data_w2(wv[1][1]), .data_w3(wv[1][2]),
        .data_x1(xv[1][0]), .data_x2(xv[1][1]), .data_x3(xv[1][2]),
        .load(load[1]), .clear(clear[1]), .res_in(res_in[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready), .res_data(res_data[1])
    );

    // MAC array model: not reset by rst, so only the sequencer's clear removes residue.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 9; e++) begin
                if (clear[d])
                    acc[d][e] <= '0;
                else if (load[d])
                    acc[d][e] <= acc[d][e] + ACCW'(wv[d][e/3]) * ACCW'(xv[d][e%3]);
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            res_in[d] = '0;
            for (int e = 0; e < 9; e++)
                res_in[d][e*ACCW +: ACCW] = acc[d][e];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9*ACCW-1:0] ref_result();
        logic [9*ACCW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(ref_a[3*i+k]) * int'(ref_b[3*k+j]);
                r[(3*i+j)*ACCW +: ACCW] = ACCW'(s);
            end
        end
        return r;
    endfunction

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_all();
        for (int e = 0; e < 9; e++) begin
            wr(1'b0, 4'(e), ref_a[e]);
            wr(1'b1, 4'(e), ref_b[e]);
        end
    endtask

    task automatic randomize_mats();
        for (int e = 0; e < 9; e++) begin
            ref_a[e] = DW'($urandom_range(0, 15));
            ref_b[e] = DW'($urandom_range(0, 15));
        end
    endtask

    // Entered at a negedge; start is sampled at the next rising edge (cycle 0).
    task automatic run_mul(input bit hold);
        logic [9*ACCW-1:0] exp_r;
        bit seen [2];
        int lat [2];
        int k;
        lat[0]    = LAT0;
        lat[1]    = LAT1;
        seen[0]   = 1'b0;
        seen[1]   = 1'b0;
        exp_r     = ref_result();
        res_ready = !hold;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= 30 && !(seen[0] && seen[1]); c++) begin
            for (int d = 0; d < 2; d++) begin
                if (c == 1) begin
                    check("clear_c1", clear[d], 1);
                    check("load_c1", load[d], 0);
                    check("busy_c1", busy[d], 1);
                end
                if (c >= 2 && c <= 4) begin
                    k = c - 2;
                    check("load_feed", load[d], 1);
                    check("clear_feed", clear[d], 0);
                    check("w_feed", {wv[d][0], wv[d][1], wv[d][2]},
                          {ref_a[k], ref_a[3+k], ref_a[6+k]});
                    check("x_feed", {xv[d][0], xv[d][1], xv[d][2]},
                          {ref_b[3*k], ref_b[3*k+1], ref_b[3*k+2]});
                end
                if (c == 5) begin
                    check("load_drain", load[d], 0);
                    check("w_drain", {wv[d][0], wv[d][1], wv[d][2], xv[d][0], xv[d][1], xv[d][2]}, 0);
                end
                if (res_valid[d] && !seen[d]) begin
                    check("latency", c, 5 + lat[d]);
                    check("result", res_data[d], exp_r);
                    seen[d] = 1'b1;
                end
            end
            if (!(seen[0] && seen[1])) @(negedge clk);
        end
        check("valid_seen0", seen[0], 1);
        check("valid_seen1", seen[1], 1);

        if (hold) begin
            for (int h = 0; h < 5; h++) begin
                wr_en   = 1'b1;
                wr_sel  = 1'($urandom_range(0, 1));
                wr_addr = 4'($urandom_range(0, 8));
                wr_data = DW'($urandom_range(0, 15));
                start   = 1'b1;
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    check("hold_valid", res_valid[d], 1);
                    check("hold_data", res_data[d], exp_r);
                    check("hold_busy", busy[d], 1);
                end
            end
            wr_en     = 1'b0;
            start     = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
        end else begin
            for (int w = 0; w < 10 && busy != 2'b00; w++) @(negedge clk);
        end
        check("done_busy", busy, 0);
        check("done_valid", res_valid, 0);
        @(negedge clk);
        check("no_requeue", {busy, res_valid}, 0);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_sel    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        res_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            ref_a[e] = '0;
            ref_b[e] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ctl", {busy[d], load[d], clear[d], res_valid[d]}, 0);
            check("rst_data", res_data[d], 0);
            check("rst_ops", {wv[d][0], wv[d][1], wv[d][2], xv[d][0], xv[d][1], xv[d][2]}, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // All threes: every element 27.
        for (int e = 0; e < 9; e++) begin
            ref_a[e] = 4'd3;
            ref_b[e] = 4'd3;
        end
        write_all();
        run_mul(1'b0);

        // Identity times 1..9 reproduces B.
        for (int e = 0; e < 9; e++) begin
            ref_a[e] = (e % 4 == 0) ? 4'd1 : 4'd0;
            ref_b[e] = DW'(e + 1);
        end
        write_all();
        run_mul(1'b0);

        // Full-scale operands: every element 675.
        for (int e = 0; e < 9; e++) begin
            ref_a[e] = 4'd15;
            ref_b[e] = 4'd15;
        end
        write_all();
        run_mul(1'b0);

        // Stalled consumer with ignored writes/starts, then a repeat shows storage unchanged.
        randomize_mats();
        write_all();
        run_mul(1'b1);
        run_mul(1'b0);

        // Out-of-range addresses are dropped.
        wr(1'b0, 4'd9, 4'hF);
        wr(1'b1, 4'd15, 4'hF);
        wr(1'b0, 4'd15, 4'hA);
        run_mul(1'b0);

        // Write in the same cycle as start uses the new value.
        ref_a[4] = ref_a[4] ^ 4'h5;
        wr_en    = 1'b1;
        wr_sel   = 1'b0;
        wr_addr  = 4'd4;
        wr_data  = ref_a[4];
        run_mul(1'b0);

        // Reset during FEED k = 1.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("feed_k1_load", load, 2'b11);
        rst = 1'b1;
        #1;
        check("arst_ctl", {busy, load, clear, res_valid}, 0);
        for (int d = 0; d < 2; d++)
            check("arst_ops", {wv[d][0], wv[d][1], wv[d][2], xv[d][0], xv[d][1], xv[d][2]}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 9; e++) begin
            ref_a[e] = '0;
            ref_b[e] = '0;
        end
        @(negedge clk);
        run_mul(1'b0);
        randomize_mats();
        write_all();
        run_mul(1'b0);

        for (int it = 0; it < 4; it++) begin
            randomize_mats();
            write_all();
            run_mul(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
